// File: rtl/dfe_out_pkg.sv
// Shared types and sizing helpers for the DFE output buffer slice.
package dfe_out_pkg;

  localparam int DFE_DATA_W = 16;

  typedef struct packed {
    logic                         sat;
    logic signed [DFE_DATA_W-1:0] data;
  } dfe_out_word_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dfe_sync_fifo.sv
// Generic first-word-fall-through FIFO with registered occupancy and full/empty flags.
module dfe_sync_fifo
  import dfe_out_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is legal when the same edge frees a slot.
  assign do_push = push & (~full | do_pop);

  // Head is forced to zero when empty so the stream outputs idle at their reset values.
  assign dout = empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[PW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dfe_output_buffer.sv
// DFE output stage: buffers core samples with a saturation tag and streams them out,
// tracking drops on full and sticky core overflow/underflow status.
module dfe_output_buffer
  import dfe_out_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   ovf_in,
  input  logic                   udf_in,
  input  logic                   clear_status,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_sat,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic                   sticky_ovf,
  output logic                   sticky_udf
);

  localparam int LW = lvl_w(DEPTH);
  localparam logic [LW-1:0]        AF_LVL  = LW'(AF_THRESH);
  localparam logic [LW-1:0]        LVL_ONE = LW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                  full;
  logic                  empty;
  logic                  pop_acc;
  logic                  push_acc;
  logic                  drop;
  logic [LW-1:0]         next_level;
  logic [DATA_WIDTH:0]   din;
  logic [DATA_WIDTH:0]   dout;

  assign pop_acc  = m_valid & m_ready;
  assign push_acc = valid_in & (~full | pop_acc);
  assign drop     = valid_in & full & ~pop_acc;
  assign din      = {ovf_in | udf_in, data_in};

  dfe_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_acc),
    .pop   (pop_acc),
    .din   (din),
    .dout  (dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign m_valid         = ~empty;
  assign {m_sat, m_data} = dout;

  // almost_full is registered from the post-edge occupancy so it tracks level exactly.
  always_comb begin
    next_level = level;
    case ({push_acc, pop_acc})
      2'b10:   next_level = level + LVL_ONE;
      2'b01:   next_level = level - LVL_ONE;
      default: next_level = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full <= 1'b0;
      drop_count  <= '0;
      sticky_ovf  <= 1'b0;
      sticky_udf  <= 1'b0;
    end else begin
      almost_full <= (next_level >= AF_LVL);

      if (drop) begin
        if (clear_status)         drop_count <= CNT_ONE;
        else if (drop_count != '1) drop_count <= drop_count + CNT_ONE;
      end else if (clear_status) begin
        drop_count <= '0;
      end

      if (valid_in && ovf_in)  sticky_ovf <= 1'b1;
      else if (clear_status)   sticky_ovf <= 1'b0;

      if (valid_in && udf_in)  sticky_udf <= 1'b1;
      else if (clear_status)   sticky_udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dfe_output_buffer.sv
// Bench for dfe_output_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dfe_output_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ovf_in;
  logic          udf_in;
  logic          clear_status;
  logic [DW-1:0] m_data;
  logic          m_sat;
  logic          m_valid;
  logic          m_ready;
  logic [4:0]    level;
  logic          almost_full;
  logic [CW-1:0] drop_count;
  logic          sticky_ovf;
  logic          sticky_udf;

  dfe_output_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ovf_in       (ovf_in),
    .udf_in       (udf_in),
    .clear_status (clear_status),
    .m_data       (m_data),
    .m_sat        (m_sat),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .almost_full  (almost_full),
    .drop_count   (drop_count),
    .sticky_ovf   (sticky_ovf),
    .sticky_udf   (sticky_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of {sat,data} words and plain integer status.
  logic [DW:0] q[$];
  int          m_drop;
  logic        m_sov;
  logic        m_sud;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_drop = 0;
      m_sov  = 1'b0;
      m_sud  = 1'b0;
    end else begin : upd
      bit p;
      bit w;
      p = (q.size() > 0) && m_ready;
      w = valid_in && ((q.size() < DEPTH) || p);
      if (p) void'(q.pop_front());
      if (w) q.push_back({ovf_in | udf_in, data_in});
      if (valid_in && !w) m_drop = clear_status ? 1 : ((m_drop < CMAX) ? m_drop + 1 : CMAX);
      else if (clear_status) m_drop = 0;
      if (valid_in && ovf_in) m_sov = 1'b1;
      else if (clear_status) m_sov = 1'b0;
      if (valid_in && udf_in) m_sud = 1'b1;
      else if (clear_status) m_sud = 1'b0;
    end
  end

  always @(negedge clk) begin : cmp
    logic [DW:0] h;
    h = (q.size() > 0) ? q[0] : '0;
    chk("m_valid",     32'(m_valid),     32'(q.size() > 0));
    chk("level",       32'(level),       32'(q.size()));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("drop_count",  32'(drop_count),  32'(m_drop));
    chk("sticky_ovf",  32'(sticky_ovf),  32'(m_sov));
    chk("sticky_udf",  32'(sticky_udf),  32'(m_sud));
    chk("m_data",      32'(m_data),      32'(h[DW-1:0]));
    chk("m_sat",       32'(m_sat),       32'(h[DW]));
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [DW-1:0] t1v [3];

  initial begin
    t1v = '{16'h1000, 16'h8000, 16'h7FFF};
    rst_n = 1'b1; valid_in = 1'b0; data_in = '0; ovf_in = 1'b0; udf_in = 1'b0;
    clear_status = 1'b0; m_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_drop", 32'(drop_count), 0);
    rst_n = 1'b1;
    cyc();

    // 1: three samples, then drain in order
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; data_in = t1v[i]; cyc();
    end
    valid_in = 1'b0;
    chk("t1_level", 32'(level), 3);
    chk("t1_valid", 32'(m_valid), 1);
    chk("t1_head", 32'(m_data), 32'h1000);
    m_ready = 1'b1;
    cyc(); chk("t1_out1", 32'(m_data), 32'h8000);
    cyc(); chk("t1_out2", 32'(m_data), 32'h7FFF);
    cyc(); chk("t1_empty", 32'(m_valid), 0);
    m_ready = 1'b0;

    // 2: overfill by four
    for (int i = 0; i < DEPTH + 4; i++) begin
      valid_in = 1'b1; data_in = 16'h2000 + 16'(i); cyc();
      chk("t2_af", 32'(almost_full), 32'(i >= 11));
    end
    valid_in = 1'b0;
    chk("t2_level", 32'(level), 16);
    chk("t2_drop", 32'(drop_count), 4);

    // 3: push and pop together while full
    valid_in = 1'b1; data_in = 16'hABCD; m_ready = 1'b1; cyc();
    valid_in = 1'b0;
    chk("t3_level", 32'(level), 16);
    chk("t3_drop", 32'(drop_count), 4);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_order", 32'(m_data), (i < 15) ? 32'h2000 + 32'(i + 1) : 32'hABCD);
      cyc();
    end
    chk("t3_empty", 32'(m_valid), 0);
    m_ready = 1'b0;

    // 4: saturation tag and sticky status
    clear_status = 1'b1; cyc(); clear_status = 1'b0;
    chk("t4_clr_drop", 32'(drop_count), 0);
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; data_in = 16'(i + 1); ovf_in = (i == 1); cyc();
    end
    valid_in = 1'b0; ovf_in = 1'b0;
    chk("t4_sov", 32'(sticky_ovf), 1);
    chk("t4_sud", 32'(sticky_udf), 0);
    m_ready = 1'b1;
    chk("t4_sat0", 32'(m_sat), 0);
    cyc(); chk("t4_sat1", 32'(m_sat), 1); chk("t4_dat1", 32'(m_data), 2);
    cyc(); chk("t4_sat2", 32'(m_sat), 0);
    cyc(); m_ready = 1'b0;
    clear_status = 1'b1; cyc(); clear_status = 1'b0;
    chk("t4_clr_sov", 32'(sticky_ovf), 0);
    clear_status = 1'b1; valid_in = 1'b1; udf_in = 1'b1; data_in = 16'h0004; cyc();
    clear_status = 1'b0; valid_in = 1'b0; udf_in = 1'b0;
    chk("t4_sud_wins", 32'(sticky_udf), 1);
    chk("t4_sat_udf", 32'(m_sat), 1);
    m_ready = 1'b1; cyc(); m_ready = 1'b0;

    // 5: drop counter saturation and clear
    for (int i = 0; i < DEPTH + 20; i++) begin
      valid_in = 1'b1; data_in = 16'h3000 + 16'(i); cyc();
    end
    valid_in = 1'b0;
    chk("t5_sat", 32'(drop_count), CMAX);
    clear_status = 1'b1; cyc(); clear_status = 1'b0;
    chk("t5_clr", 32'(drop_count), 0);
    clear_status = 1'b1; valid_in = 1'b1; cyc();
    clear_status = 1'b0; valid_in = 1'b0;
    chk("t5_drop_wins", 32'(drop_count), 1);

    // 6: asynchronous reset mid-stream
    m_ready = 1'b1; repeat (9) cyc(); m_ready = 1'b0;
    chk("t6_level7", 32'(level), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_level", 32'(level), 0);
    chk("t6_async_valid", 32'(m_valid), 0);
    chk("t6_async_data", 32'(m_data), 0);
    chk("t6_async_drop", 32'(drop_count), 0);
    cyc();
    rst_n = 1'b1;
    valid_in = 1'b1; data_in = 16'h5A5A; cyc();
    valid_in = 1'b0;
    chk("t6_after", 32'(m_data), 32'h5A5A);
    chk("t6_level1", 32'(level), 1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
